// File: rtl/para_port_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | para_port_sched_pkg: shared sizes, state type and budget helper   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package para_port_sched_pkg;

  localparam int NUM_PORT         = 5;
  localparam int PC_INDEX_WIDTH   = 3;
  localparam int PSCHED_MAX_SLOTS = 5;

  localparam int NUM_CH    = NUM_PORT - 1;
  localparam int NUM_OUT   = NUM_PORT - 1;
  localparam int OCC_W     = PC_INDEX_WIDTH;
  localparam int CH_W      = 2;
  localparam int STARVE_TH = 8;
  localparam int WAIT_W    = 4;

  typedef logic [NUM_OUT-1:0] port_vec_t;
  typedef logic [CH_W-1:0]    ch_idx_t;

  typedef enum logic [0:0] {
    CH_IDLE = 1'b0,
    CH_HOLD = 1'b1
  } ch_state_t;

  // Free fork slots; an over-reported occupancy yields zero rather than wrapping.
  function automatic logic [OCC_W-1:0] fork_budget(input logic [OCC_W-1:0] occ,
                                                   input int max_slots);
    if (int'(occ) >= max_slots) return '0;
    return OCC_W'(max_slots - int'(occ));
  endfunction

endpackage
`default_nettype wire

// File: rtl/para_port_sched_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | para_port_sched_if: descriptor load, fork occupancy, grant bus    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface para_port_sched_if;
  import para_port_sched_pkg::*;

  logic [NUM_CH-1:0]         in_valid;
  logic [NUM_CH-1:0]         in_mc;
  logic [NUM_CH*NUM_OUT-1:0] in_ppv;
  logic [NUM_CH-1:0]         in_ready;
  logic [OCC_W-1:0]          fork_occ;
  logic [NUM_CH*NUM_OUT-1:0] grant_apv;
  logic [NUM_CH-1:0]         done;
  logic [CH_W-1:0]           rr_ptr_o;

  modport master (
    output in_valid, in_mc, in_ppv, fork_occ,
    input  in_ready, grant_apv, done, rr_ptr_o
  );

  modport slave (
    input  in_valid, in_mc, in_ppv, fork_occ,
    output in_ready, grant_apv, done, rr_ptr_o
  );

endinterface
`default_nettype wire

// File: rtl/para_port_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | para_port_pick: one channel's port pick from the still-free ports |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module para_port_pick
  import para_port_sched_pkg::*;
(
  input  port_vec_t        res_ppv,
  input  port_vec_t        taken,
  input  logic             mc,
  input  logic [OCC_W-1:0] budget_in,
  output port_vec_t        grant,
  output port_vec_t        taken_out,
  output logic [OCC_W-1:0] budget_out
);

  port_vec_t        avail;
  logic [OCC_W-1:0] budget;
  logic             first_free;

  assign avail = res_ppv & ~taken;

  // The first port of any descriptor is free; each further multicast port costs one slot.
  always_comb begin
    grant      = '0;
    budget     = budget_in;
    first_free = 1'b1;
    for (int p = 0; p < NUM_OUT; p++) begin
      if (avail[p]) begin
        if (first_free) begin
          grant[p]   = 1'b1;
          first_free = 1'b0;
        end else if (mc && (budget != '0)) begin
          grant[p] = 1'b1;
          budget   = budget - OCC_W'(1);
        end
      end
    end
  end

  assign taken_out  = taken | grant;
  assign budget_out = budget;

endmodule
`default_nettype wire

// File: rtl/para_port_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | para_port_sched: rotating-priority port allocator with fork cap   |
// | Optional PARA_PORT_SCHED_STARVE_EN: starving channels go first.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module para_port_sched
  import para_port_sched_pkg::*;
#(
  parameter int MAX_SLOTS = PSCHED_MAX_SLOTS
) (
  input  logic               clk,
  input  logic               rst_n,
  para_port_sched_if.slave   bus
);

  ch_state_t         state     [NUM_CH];
  ch_state_t         state_nxt [NUM_CH];
  port_vec_t         res_ppv   [NUM_CH];
  port_vec_t         res_nxt   [NUM_CH];
  port_vec_t         new_ppv   [NUM_CH];
  port_vec_t         grant_ch  [NUM_CH];
  port_vec_t         pick_grant[NUM_CH];
  ch_idx_t           order     [NUM_CH];
  logic [NUM_CH-1:0] mc_q, mc_nxt, busy, done_w, ready_w, accept;
  ch_idx_t           rr_ptr;
  logic              any_grant;
  logic [OCC_W-1:0]  budget_init;
  logic [OCC_W-1:0]  budget_left;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign busy[c]    = (state[c] == CH_HOLD);
    assign new_ppv[c] = bus.in_ppv[c*NUM_OUT +: NUM_OUT];
  end

`ifdef PARA_PORT_SCHED_STARVE_EN
  logic [WAIT_W-1:0] wait_cnt [NUM_CH];
  logic [NUM_CH-1:0] starving;
  logic [CH_W:0]     slot;
  ch_idx_t           rot_idx;

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst_n || !busy[c] || (grant_ch[c] != '0)) begin
        wait_cnt[c] <= '0;
      end else if (wait_cnt[c] != '1) begin
        wait_cnt[c] <= wait_cnt[c] + WAIT_W'(1);
      end
    end
  end

  // Starving channels in index order, then everyone else in rotation order.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      order[c]    = '0;
      starving[c] = (wait_cnt[c] >= WAIT_W'(STARVE_TH));
    end
    slot    = '0;
    rot_idx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (starving[c]) begin
        order[slot[CH_W-1:0]] = ch_idx_t'(c);
        slot                  = slot + (CH_W+1)'(1);
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      rot_idx = rr_ptr + ch_idx_t'(k);
      if (!starving[rot_idx]) begin
        order[slot[CH_W-1:0]] = rot_idx;
        slot                  = slot + (CH_W+1)'(1);
      end
    end
  end
`else
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      order[k] = rr_ptr + ch_idx_t'(k);
    end
  end
`endif

  assign budget_init = fork_budget(bus.fork_occ, MAX_SLOTS);

  // Taken mask and fork budget ripple through the pickers in visit order.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_chain
    port_vec_t        taken_in, taken_out, res, grant;
    logic [OCC_W-1:0] budget_in, budget_out;

    if (k == 0) begin : g_head
      assign taken_in  = '0;
      assign budget_in = budget_init;
    end else begin : g_link
      assign taken_in  = g_chain[k-1].taken_out;
      assign budget_in = g_chain[k-1].budget_out;
    end

    assign res           = busy[order[k]] ? res_ppv[order[k]] : '0;
    assign pick_grant[k] = grant;

    para_port_pick u_pick (
      .res_ppv    (res),
      .taken      (taken_in),
      .mc         (mc_q[order[k]]),
      .budget_in  (budget_in),
      .grant      (grant),
      .taken_out  (taken_out),
      .budget_out (budget_out)
    );
  end

  assign any_grant   = |g_chain[NUM_CH-1].taken_out;
  assign budget_left = g_chain[NUM_CH-1].budget_out;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      grant_ch[c] = '0;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      grant_ch[order[k]] = pick_grant[k];
    end
  end

  // Per-channel IDLE/HOLD next state; a retiring channel may reload in the same cycle.
  always_comb begin
    done_w  = '0;
    ready_w = '0;
    accept  = '0;
    mc_nxt  = mc_q;
    for (int c = 0; c < NUM_CH; c++) begin
      state_nxt[c] = state[c];
      res_nxt[c]   = res_ppv[c];
      done_w[c]    = busy[c] && ((res_ppv[c] & ~grant_ch[c]) == '0);
      ready_w[c]   = !busy[c] || done_w[c];
      accept[c]    = bus.in_valid[c] && ready_w[c] && (new_ppv[c] != '0);
      case (state[c])
        CH_IDLE: begin
          if (accept[c]) begin
            state_nxt[c] = CH_HOLD;
            res_nxt[c]   = new_ppv[c];
            mc_nxt[c]    = bus.in_mc[c];
          end
        end
        CH_HOLD: begin
          res_nxt[c] = res_ppv[c] & ~grant_ch[c];
          if (accept[c]) begin
            res_nxt[c] = new_ppv[c];
            mc_nxt[c]  = bus.in_mc[c];
          end else if (done_w[c]) begin
            state_nxt[c] = CH_IDLE;
          end
        end
        default: state_nxt[c] = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state[c]   <= CH_IDLE;
        res_ppv[c] <= '0;
      end
      mc_q   <= '0;
      rr_ptr <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state[c]   <= state_nxt[c];
        res_ppv[c] <= res_nxt[c];
      end
      mc_q <= mc_nxt;
      if (any_grant) begin
        rr_ptr <= rr_ptr + ch_idx_t'(1);
      end
    end
  end

  always_comb begin
    bus.grant_apv = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.grant_apv[c*NUM_OUT +: NUM_OUT] = rst_n ? grant_ch[c] : '0;
    end
  end

  assign bus.done     = rst_n ? done_w  : '0;
  assign bus.in_ready = rst_n ? ready_w : '0;
  assign bus.rr_ptr_o = rr_ptr;

  // Fork slots are only ever consumed, never created, along the chain.
  assert property (@(posedge clk) disable iff (!rst_n) budget_left <= budget_init);

endmodule
`default_nettype wire

// File: tb/tb_para_port_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_para_port_sched: directed cases plus random traffic vs a model |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_para_port_sched;
  import para_port_sched_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  para_port_sched_if bus();

  para_port_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  bit       m_busy [4];
  bit [3:0] m_res  [4];
  bit       m_mc   [4];
  int       m_wait [4];
  int       m_rr = 0;
  bit [3:0] e_grant[4];
  bit [3:0] e_done, e_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected outputs straight from the allocation rules, using the model's state.
  task automatic model_outputs();
    int       vq[$];
    bit [3:0] used;
    int       budget, occ, c, n;
    bit       starve;
    for (int i = 0; i < 4; i++) e_grant[i] = 4'b0;
    e_done  = 4'b0;
    e_ready = 4'b0;
    if (!rst_n) return;
    occ    = int'(bus.fork_occ);
    budget = (occ >= PSCHED_MAX_SLOTS) ? 0 : PSCHED_MAX_SLOTS - occ;
`ifdef PARA_PORT_SCHED_STARVE_EN
    for (int i = 0; i < 4; i++)
      if (m_busy[i] && m_wait[i] >= STARVE_TH) vq.push_back(i);
    for (int k = 0; k < 4; k++) begin
      c      = (m_rr + k) % 4;
      starve = m_busy[c] && m_wait[c] >= STARVE_TH;
      if (!starve) vq.push_back(c);
    end
`else
    for (int k = 0; k < 4; k++) vq.push_back((m_rr + k) % 4);
`endif
    used = 4'b0;
    foreach (vq[i]) begin
      c = vq[i];
      n = 0;
      if (m_busy[c]) begin
        for (int p = 0; p < 4; p++) begin
          if (m_res[c][p] && !used[p]) begin
            if (n == 0) begin
              e_grant[c][p] = 1'b1;
              n = 1;
            end else if (m_mc[c] && budget > 0) begin
              e_grant[c][p] = 1'b1;
              budget--;
            end
          end
        end
        used |= e_grant[c];
      end
    end
    for (int i = 0; i < 4; i++) begin
      e_done[i]  = m_busy[i] && ((m_res[i] & ~e_grant[i]) == 4'b0);
      e_ready[i] = !m_busy[i] || e_done[i];
    end
  endtask

  task automatic model_advance();
    bit       any;
    bit [3:0] ppv;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_busy[i] = 0; m_res[i] = 0; m_mc[i] = 0; m_wait[i] = 0;
      end
      m_rr = 0;
      return;
    end
    any = 0;
    for (int i = 0; i < 4; i++) begin
      if (!m_busy[i] || e_grant[i] != 4'b0) m_wait[i] = 0;
      else if (m_wait[i] < 15) m_wait[i] = m_wait[i] + 1;
      ppv = bus.in_ppv[i*4 +: 4];
      if (bus.in_valid[i] && e_ready[i] && ppv != 4'b0) begin
        m_busy[i] = 1;
        m_res[i]  = ppv;
        m_mc[i]   = bus.in_mc[i];
      end else if (m_busy[i]) begin
        m_res[i] = m_res[i] & ~e_grant[i];
        if (e_done[i]) m_busy[i] = 0;
      end
      if (e_grant[i] != 4'b0) any = 1;
    end
    if (any) m_rr = (m_rr + 1) % 4;
  endtask

  always @(negedge clk) begin
    logic [15:0] eg;
    model_outputs();
    for (int i = 0; i < 4; i++) eg[i*4 +: 4] = e_grant[i];
    chk("grant_apv", bus.grant_apv, eg);
    chk("done", bus.done, e_done);
    chk("in_ready", bus.in_ready, e_ready);
    chk("rr_ptr_o", bus.rr_ptr_o, m_rr[1:0]);
    model_advance();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] mc,
                       input logic [15:0] ppv, input logic [2:0] occ);
    bus.in_valid = v;
    bus.in_mc    = mc;
    bus.in_ppv   = ppv;
    bus.fork_occ = occ;
  endtask

  initial begin
    logic [15:0] rp;
    bit          served;
    drive(4'hF, 4'h0, 16'hFFFF, 3'd0);
    step(); step(); #2;
    chk("rst_ready", bus.in_ready, 4'h0);
    chk("rst_grant", bus.grant_apv, 16'h0);
    chk("rst_done", bus.done, 4'h0);
    rst_n = 1'b1;
    drive(4'h0, 4'h0, 16'h0, 3'd0);
    step(); #2;
    chk("rst_rr", bus.rr_ptr_o, 2'd0);

    // ch0 unicast 0110: one port per cycle, lowest first
    drive(4'h1, 4'h0, 16'h0006, 3'd0);
    step(); drive(4'h0, 4'h0, 16'h0, 3'd0); #2;
    chk("uc_g1", bus.grant_apv, 16'h0002);
    chk("uc_d1", bus.done, 4'h0);
    step(); #2;
    chk("uc_g2", bus.grant_apv, 16'h0004);
    chk("uc_d2", bus.done, 4'h1);
    chk("uc_rr", bus.rr_ptr_o, 2'd1);
    step(); #2;
    chk("uc_rr2", bus.rr_ptr_o, 2'd2);

    // ch0 and ch2 contend for port 0 with rr_ptr=2
    drive(4'h5, 4'h0, 16'h0101, 3'd0);
    step(); drive(4'h0, 4'h0, 16'h0, 3'd0); #2;
    chk("rr_g1", bus.grant_apv, 16'h0100);
    step(); #2;
    chk("rr_g2", bus.grant_apv, 16'h0001);
    chk("rr_d2", bus.done, 4'h1);
    step();

    // ch1 multicast 1111 with two free fork slots
    drive(4'h2, 4'h2, 16'h00F0, 3'd3);
    step(); drive(4'h0, 4'h0, 16'h0, 3'd3); #2;
    chk("mc_g1", bus.grant_apv, 16'h0070);
    chk("mc_d1", bus.done, 4'h0);
    step(); #2;
    chk("mc_g2", bus.grant_apv, 16'h0080);
    chk("mc_d2", bus.done, 4'h2);
    step();

    // over-reported occupancy: no forks at all
    drive(4'h8, 4'h8, 16'hA000, 3'd7);
    step(); drive(4'h0, 4'h0, 16'h0, 3'd7); #2;
    chk("sat_g1", bus.grant_apv, 16'h2000);
    step(); #2;
    chk("sat_g2", bus.grant_apv, 16'h8000);
    chk("sat_d2", bus.done, 4'h8);
    step();

    // ch1-3 keep reloading port 0; ch0 must still be served promptly
    drive(4'hE, 4'h0, 16'h1110, 3'd0);
    step();
    drive(4'hF, 4'h0, 16'h1111, 3'd0);
    step();
    served = 1'b0;
    for (int i = 0; i < 5 && !served; i++) begin
      #2;
      if (bus.grant_apv[3:0] == 4'h1) served = 1'b1;
      else step();
    end
    chk("ch0_served", served, 1'b1);
    drive(4'h0, 4'h0, 16'h0, 3'd0);
    repeat (6) step();

    // randomized traffic, checked every cycle by the model
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int c = 0; c < 4; c++)
        rp[c*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      drive(4'($urandom), 4'($urandom), rp,
            ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)));
      step();
    end
    rst_n = 1'b1;
    drive(4'h0, 4'h0, 16'h0, 3'd0);
    repeat (12) step();
    @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
